// File: rtl/wb_init_pkg.sv
// Shared definitions for the Wishbone classic initiator: state encoding,
// full byte-select constant and default error data.
package wb_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0]  WB_SEL_ALL       = 4'hF;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_DEAD;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Strobe-age counter; expired flags the last cycle a strobe may wait for ack.
module wb_timeout_ctr #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] CNT_MAX  = '1;

  logic [W-1:0] cnt_q;

  assign expired = (LIMIT != 0) && (cnt_q == CNT_LAST);

  // Saturates so a disabled timeout never wraps back into range
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/wb_simple_initiator.sv
// Single-outstanding Wishbone classic initiator: one bus cycle per command,
// response returned on a valid/ready stream, timeout aborts unacked cycles.
module wb_simple_initiator
  import wb_init_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = 8,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy
);

  if ((TIMEOUT_CYCLES >> TIMEOUT_W) != 0) begin : g_tmo_width_bad
    $fatal(1, "TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
  end

  state_e state_q;
  logic   accept;
  logic   tmo_expired;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_ready && cmd_valid;

  wb_timeout_ctr #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept),
    .enable  ((state_q == ST_BUS) && !wb_ack_i),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            wb_adr_o <= cmd_adr;
            wb_dat_o <= cmd_dat;
            wb_we_o  <= cmd_we;
            wb_sel_o <= cmd_we ? cmd_sel : WB_SEL_ALL;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state_q  <= ST_BUS;
          end
        end
        // Ack takes priority over a timeout landing on the same edge
        ST_BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            rsp_dat   <= wb_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end else if (tmo_expired) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            rsp_dat   <= ERR_DATA;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
